// File: rtl/csr_pkg.sv
// csr_pkg: shared CSR addresses, bit positions, op encodings and cause codes.
package csr_pkg;
    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MISA      = 12'h301;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MTVAL     = 12'h343;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_CYCLE     = 12'hC00;
    localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
    localparam logic [11:0] CSR_INSTRET   = 12'hC02;
    localparam logic [11:0] CSR_INSTRETH  = 12'hC82;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;
    localparam int MIE_MTIE     = 7;
    localparam int MIE_MEIE     = 11;
    localparam int MIP_MTIP     = 7;
    localparam int MIP_MEIP     = 11;
    localparam logic [31:0] MSTATUS_MPP = 32'h0000_1800;

    localparam logic [31:0] CAUSE_MEI = 32'h8000_000B;
    localparam logic [31:0] CAUSE_MTI = 32'h8000_0007;

    localparam logic [1:0] MTVEC_DIRECT   = 2'd0;
    localparam logic [1:0] MTVEC_VECTORED = 2'd1;

    typedef enum logic [1:0] {OP_WRITE, OP_SET, OP_CLEAR, OP_NONE} csr_op_e;

    function automatic logic [31:0] csr_apply(csr_op_e op, logic [31:0] old_v, logic [31:0] di);
        return op == OP_SET ? (old_v | di) : op == OP_CLEAR ? (old_v & ~di) : di;
    endfunction
endpackage

// File: rtl/csr_if.sv
// csr_if: CSR access, trap control and interrupt signals between the core and csr_unit.
interface csr_if #(parameter int XLEN = 32);
    logic            i_we;
    logic [1:0]      i_op;
    logic [11:0]     i_a;
    logic [XLEN-1:0] i_di;
    logic [XLEN-1:0] o_do;
    logic            o_illegal;
    logic            i_trap;
    logic [XLEN-1:0] i_trap_cause;
    logic [XLEN-1:0] i_trap_pc;
    logic [XLEN-1:0] i_trap_val;
    logic            i_mret;
    logic            i_retire;
    logic            i_irq_ext;
    logic            i_irq_timer;
    logic            o_irq_pending;
    logic [XLEN-1:0] o_irq_cause;
    logic [XLEN-1:0] o_trap_target;
    logic [XLEN-1:0] o_mepc_do;

    modport master (
        output i_we, i_op, i_a, i_di, i_trap, i_trap_cause, i_trap_pc, i_trap_val,
               i_mret, i_retire, i_irq_ext, i_irq_timer,
        input  o_do, o_illegal, o_irq_pending, o_irq_cause, o_trap_target, o_mepc_do
    );
    modport slave (
        input  i_we, i_op, i_a, i_di, i_trap, i_trap_cause, i_trap_pc, i_trap_val,
               i_mret, i_retire, i_irq_ext, i_irq_timer,
        output o_do, o_illegal, o_irq_pending, o_irq_cause, o_trap_target, o_mepc_do
    );
endinterface

// File: rtl/csr_counter64.sv
// csr_counter64: 64-bit counter; a write to either half replaces it and suppresses that cycle's increment.
module csr_counter64 (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_inc,
    input  logic        i_we_lo,
    input  logic        i_we_hi,
    input  logic [31:0] i_wdata,
    output logic [63:0] o_count
);
    logic [63:0] r_count;

    always_ff @(posedge clk) begin
        if (reset) r_count <= '0;
        else if (i_we_lo) r_count[31:0] <= i_wdata;
        else if (i_we_hi) r_count[63:32] <= i_wdata;
        else if (i_inc) r_count <= r_count + 64'd1;
    end

    assign o_count = r_count;
endmodule

// File: rtl/csr_unit.sv
// csr_unit: RV32 machine-mode CSR file with trap stacking, mret and interrupt gating.
// Define CSR_COUNTERS_EN to add mcycle/minstret and their read-only user aliases.
module csr_unit
    import csr_pkg::*;
#(
    parameter int          XLEN       = 32,
    parameter logic [31:0] HART_ID    = 32'd0,
    parameter logic [31:0] MISA_VALUE = 32'h4000_0100
) (
    input logic  clk,
    input logic  reset,
    csr_if.slave bus
);
    logic r_st_mie, r_st_mpie, r_meie, r_mtie;
    logic [XLEN-1:0] r_mtvec, r_mscratch, r_mepc, r_mcause, r_mtval;
    logic [XLEN-1:0] w_mstatus, w_mie, w_mip, w_rd, w_new, w_vec_off;
    logic w_impl, w_illegal, w_wr, w_ext_on, w_tim_on, w_unused;
`ifdef CSR_COUNTERS_EN
    logic [63:0] w_mcycle, w_minstret;
`endif

    assign w_mstatus = MSTATUS_MPP | (XLEN'(r_st_mpie) << MSTATUS_MPIE) | (XLEN'(r_st_mie) << MSTATUS_MIE);
    assign w_mie     = (XLEN'(r_meie) << MIE_MEIE) | (XLEN'(r_mtie) << MIE_MTIE);
    assign w_mip     = (XLEN'(bus.i_irq_ext) << MIP_MEIP) | (XLEN'(bus.i_irq_timer) << MIP_MTIP);

    always_comb begin
        w_rd   = '0;
        w_impl = 1'b1;
        case (bus.i_a)
            CSR_MSTATUS:  w_rd = w_mstatus;
            CSR_MISA:     w_rd = MISA_VALUE;
            CSR_MIE:      w_rd = w_mie;
            CSR_MTVEC:    w_rd = r_mtvec;
            CSR_MSCRATCH: w_rd = r_mscratch;
            CSR_MEPC:     w_rd = r_mepc;
            CSR_MCAUSE:   w_rd = r_mcause;
            CSR_MTVAL:    w_rd = r_mtval;
            CSR_MIP:      w_rd = w_mip;
            CSR_MHARTID:  w_rd = HART_ID;
`ifdef CSR_COUNTERS_EN
            CSR_MCYCLE, CSR_CYCLE:       w_rd = w_mcycle[31:0];
            CSR_MCYCLEH, CSR_CYCLEH:     w_rd = w_mcycle[63:32];
            CSR_MINSTRET, CSR_INSTRET:   w_rd = w_minstret[31:0];
            CSR_MINSTRETH, CSR_INSTRETH: w_rd = w_minstret[63:32];
`endif
            default:      w_impl = 1'b0;
        endcase
    end

    // The 0xC00-0xFFF quadrant is read-only, so any write attempt there is illegal.
    assign w_illegal     = !w_impl || (bus.i_we && bus.i_a[11:10] == 2'b11);
    assign w_wr          = bus.i_we && bus.i_op != OP_NONE && !w_illegal && !bus.i_trap && !bus.i_mret;
    assign w_new         = csr_apply(csr_op_e'(bus.i_op), w_rd, bus.i_di);
    assign bus.o_do      = w_rd;
    assign bus.o_illegal = w_illegal;

    assign w_ext_on          = r_meie && bus.i_irq_ext;
    assign w_tim_on          = r_mtie && bus.i_irq_timer;
    assign bus.o_irq_pending = r_st_mie && (w_ext_on || w_tim_on);
    assign bus.o_irq_cause   = !r_st_mie ? '0 : w_ext_on ? CAUSE_MEI : w_tim_on ? CAUSE_MTI : '0;
    assign w_vec_off         = (r_mtvec[1:0] == MTVEC_VECTORED && bus.i_trap_cause[XLEN-1]) ?
                               {bus.i_trap_cause[XLEN-3:0], 2'b00} : '0;
    assign bus.o_trap_target = {r_mtvec[XLEN-1:2], 2'b00} + w_vec_off;
    assign bus.o_mepc_do     = r_mepc;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_st_mie   <= 1'b0;
            r_st_mpie  <= 1'b0;
            r_meie     <= 1'b0;
            r_mtie     <= 1'b0;
            r_mtvec    <= '0;
            r_mscratch <= '0;
            r_mepc     <= '0;
            r_mcause   <= '0;
            r_mtval    <= '0;
        end else if (bus.i_trap) begin
            r_mepc    <= {bus.i_trap_pc[XLEN-1:2], 2'b00};
            r_mcause  <= bus.i_trap_cause;
            r_mtval   <= bus.i_trap_val;
            r_st_mpie <= r_st_mie;
            r_st_mie  <= 1'b0;
        end else if (bus.i_mret) begin
            r_st_mie  <= r_st_mpie;
            r_st_mpie <= 1'b1;
        end else if (w_wr) begin
            case (bus.i_a)
                CSR_MSTATUS: begin
                    r_st_mie  <= w_new[MSTATUS_MIE];
                    r_st_mpie <= w_new[MSTATUS_MPIE];
                end
                CSR_MIE: begin
                    r_meie <= w_new[MIE_MEIE];
                    r_mtie <= w_new[MIE_MTIE];
                end
                CSR_MTVEC:    if (w_new[1:0] inside {MTVEC_DIRECT, MTVEC_VECTORED}) r_mtvec <= w_new;
                CSR_MSCRATCH: r_mscratch <= w_new;
                CSR_MEPC:     r_mepc <= {w_new[XLEN-1:2], 2'b00};
                CSR_MCAUSE:   r_mcause <= w_new;
                CSR_MTVAL:    r_mtval <= w_new;
                default: ;
            endcase
        end
    end

`ifdef CSR_COUNTERS_EN
    csr_counter64 u_mcycle (
        .clk(clk), .reset(reset), .i_inc(1'b1),
        .i_we_lo(w_wr && bus.i_a == CSR_MCYCLE), .i_we_hi(w_wr && bus.i_a == CSR_MCYCLEH),
        .i_wdata(w_new), .o_count(w_mcycle)
    );
    csr_counter64 u_minstret (
        .clk(clk), .reset(reset), .i_inc(bus.i_retire),
        .i_we_lo(w_wr && bus.i_a == CSR_MINSTRET), .i_we_hi(w_wr && bus.i_a == CSR_MINSTRETH),
        .i_wdata(w_new), .o_count(w_minstret)
    );
    assign w_unused = ^{bus.i_trap_cause[XLEN-2], bus.i_trap_pc[1:0]};
`else
    assign w_unused = ^{bus.i_trap_cause[XLEN-2], bus.i_trap_pc[1:0], bus.i_retire};
`endif
endmodule

// File: tb/tb_csr_unit.sv
// tb_csr_unit: directed and randomized checks of csr_unit against a behavioural CSR model.
// Honours CSR_COUNTERS_EN the same way as the design.
module tb_csr_unit;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    csr_if bus();
    csr_unit dut (.clk(clk), .reset(reset), .bus(bus));

    int n_pass = 0;
    int n_chk = 0;
    logic [31:0] m_mstatus, m_mie, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval;
    logic [31:0] n_mstatus, n_mie, n_mtvec, n_mscratch, n_mepc, n_mcause, n_mtval;
    logic [63:0] m_cyc, m_ins, n_cyc, n_ins;
    logic [11:0] addrs [20] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                                12'h343, 12'h344, 12'hF14, 12'hB00, 12'hB80, 12'hB02, 12'hB82,
                                12'hC00, 12'hC80, 12'hC02, 12'hC82, 12'h345, 12'h7C0};

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic bit mimpl(logic [11:0] a);
`ifdef CSR_COUNTERS_EN
        if (a inside {12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00, 12'hC80, 12'hC02, 12'hC82}) return 1'b1;
`endif
        return a inside {12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343, 12'h344, 12'hF14};
    endfunction

    function automatic logic [31:0] mread(logic [11:0] a);
        if (!mimpl(a)) return 32'h0;
        case (a)
            12'h300: return m_mstatus;
            12'h301: return 32'h4000_0100;
            12'h304: return m_mie;
            12'h305: return m_mtvec;
            12'h340: return m_mscratch;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'h343: return m_mtval;
            12'h344: return (bus.i_irq_timer ? 32'h80 : 32'h0) + (bus.i_irq_ext ? 32'h800 : 32'h0);
            12'hB00, 12'hC00: return m_cyc[31:0];
            12'hB80, 12'hC80: return m_cyc[63:32];
            12'hB02, 12'hC02: return m_ins[31:0];
            12'hB82, 12'hC82: return m_ins[63:32];
            default: return 32'h0;
        endcase
    endfunction

    task automatic reset_model();
        m_mstatus = 32'h1800; m_mie = 0; m_mtvec = 0; m_mscratch = 0;
        m_mepc = 0; m_mcause = 0; m_mtval = 0; m_cyc = 0; m_ins = 0;
    endtask

    task automatic half();
        logic [31:0] old_v, nv, tgt;
        bit ill, wr, ext_on, tim_on;
        @(negedge clk);
        ill = !mimpl(bus.i_a) || (bus.i_we && bus.i_a >= 12'hC00);
        ext_on = (m_mstatus & 32'h8) != 0 && (m_mie & 32'h800) != 0 && bus.i_irq_ext;
        tim_on = (m_mstatus & 32'h8) != 0 && (m_mie & 32'h80) != 0 && bus.i_irq_timer;
        tgt = (m_mtvec & ~32'h3) + ((m_mtvec % 4 == 1 && bus.i_trap_cause >= 32'h8000_0000) ?
              (bus.i_trap_cause - 32'h8000_0000) * 4 : 32'h0);
        chk("do", bus.o_do, mread(bus.i_a));
        chk("illegal", 32'(bus.o_illegal), 32'(ill));
        chk("irq_pending", 32'(bus.o_irq_pending), 32'(ext_on || tim_on));
        chk("irq_cause", bus.o_irq_cause, ext_on ? 32'h8000_000B : tim_on ? 32'h8000_0007 : 32'h0);
        chk("trap_target", bus.o_trap_target, tgt);
        chk("mepc_do", bus.o_mepc_do, m_mepc);
        n_mstatus = m_mstatus; n_mie = m_mie; n_mtvec = m_mtvec; n_mscratch = m_mscratch;
        n_mepc = m_mepc; n_mcause = m_mcause; n_mtval = m_mtval;
        n_cyc = m_cyc + 1;
        n_ins = m_ins + (bus.i_retire ? 1 : 0);
        wr = bus.i_we && bus.i_op != 2'd3 && !ill;
        old_v = mread(bus.i_a);
        nv = bus.i_op == 2'd0 ? bus.i_di : bus.i_op == 2'd1 ? (old_v | bus.i_di) : (old_v & ~bus.i_di);
        if (bus.i_trap) begin
            n_mepc = bus.i_trap_pc & ~32'h3;
            n_mcause = bus.i_trap_cause;
            n_mtval = bus.i_trap_val;
            n_mstatus = 32'h1800 | ((m_mstatus & 32'h8) << 4);
        end else if (bus.i_mret) begin
            n_mstatus = 32'h1880 | ((m_mstatus & 32'h80) >> 4);
        end else if (wr) begin
            case (bus.i_a)
                12'h300: n_mstatus = 32'h1800 | (nv & 32'h88);
                12'h304: n_mie = nv & 32'h880;
                12'h305: if (nv % 4 < 2) n_mtvec = nv;
                12'h340: n_mscratch = nv;
                12'h341: n_mepc = nv & ~32'h3;
                12'h342: n_mcause = nv;
                12'h343: n_mtval = nv;
                12'hB00: n_cyc = {m_cyc[63:32], nv};
                12'hB80: n_cyc = {nv, m_cyc[31:0]};
                12'hB02: n_ins = {m_ins[63:32], nv};
                12'hB82: n_ins = {nv, m_ins[31:0]};
                default: ;
            endcase
        end
        if (reset) begin
            n_mstatus = 32'h1800; n_mie = 0; n_mtvec = 0; n_mscratch = 0;
            n_mepc = 0; n_mcause = 0; n_mtval = 0; n_cyc = 0; n_ins = 0;
        end
    endtask

    task automatic fin();
        @(posedge clk);
        #1;
        m_mstatus = n_mstatus; m_mie = n_mie; m_mtvec = n_mtvec; m_mscratch = n_mscratch;
        m_mepc = n_mepc; m_mcause = n_mcause; m_mtval = n_mtval; m_cyc = n_cyc; m_ins = n_ins;
    endtask

    task automatic cyc();
        half();
        fin();
    endtask

    task automatic idle();
        bus.i_we = 0; bus.i_op = 0; bus.i_a = 12'h300; bus.i_di = 0;
        bus.i_trap = 0; bus.i_mret = 0; bus.i_retire = 0; reset = 0;
    endtask

    task automatic wr(logic [11:0] a, logic [1:0] op, logic [31:0] di);
        idle();
        bus.i_we = 1; bus.i_op = op; bus.i_a = a; bus.i_di = di;
        cyc();
    endtask

    task automatic peek(string tag, logic [11:0] a, logic [31:0] exp);
        idle();
        bus.i_a = a;
        half();
        chk(tag, bus.o_do, exp);
        fin();
    endtask

    initial begin
        idle();
        reset = 1;
        bus.i_trap_cause = 0; bus.i_trap_pc = 0; bus.i_trap_val = 0;
        bus.i_irq_ext = 0; bus.i_irq_timer = 0;
        repeat (2) @(posedge clk);
        #1;
        reset_model();
        idle();
        // reset values
        peek("rst_mstatus", 12'h300, 32'h1800);
        peek("rst_mtvec", 12'h305, 32'h0);
        peek("rst_mepc", 12'h341, 32'h0);
        peek("rst_mcause", 12'h342, 32'h0);
        idle();
        bus.i_a = 12'h301;
        half();
        chk("rst_misa", bus.o_do, 32'h4000_0100);
        chk("misa_legal", 32'(bus.o_illegal), 32'h0);
        fin();
        // mtvec mode filtering
        wr(12'h305, 2'd0, 32'hFC);
        wr(12'h305, 2'd0, 32'hFF);
        wr(12'h305, 2'd0, 32'hFE);
        peek("mtvec_mode_reject", 12'h305, 32'hFC);
        wr(12'h305, 2'd1, 32'h2);
        peek("mtvec_set_reject", 12'h305, 32'hFC);
        wr(12'h305, 2'd0, 32'hFD);
        peek("mtvec_vectored", 12'h305, 32'hFD);
        // mscratch set/clear and read-only hartid
        wr(12'h340, 2'd0, 32'hF0F0);
        wr(12'h340, 2'd1, 32'h000F);
        peek("mscratch_set", 12'h340, 32'hF0FF);
        wr(12'h340, 2'd2, 32'h00F0);
        peek("mscratch_clear", 12'h340, 32'hF00F);
        idle();
        bus.i_we = 1; bus.i_a = 12'hF14; bus.i_di = 32'h5;
        half();
        chk("hartid_write_illegal", 32'(bus.o_illegal), 32'h1);
        fin();
        peek("hartid_value", 12'hF14, 32'h0);
        // trap entry (with a concurrent write that must be dropped) and mret
        wr(12'h300, 2'd0, 32'h8);
        idle();
        bus.i_trap = 1; bus.i_trap_pc = 32'h103; bus.i_trap_cause = 32'h2; bus.i_trap_val = 32'hDEAD;
        bus.i_we = 1; bus.i_a = 12'h340; bus.i_di = 32'h1234;
        cyc();
        peek("trap_mepc", 12'h341, 32'h100);
        peek("trap_mcause", 12'h342, 32'h2);
        peek("trap_mtval", 12'h343, 32'hDEAD);
        peek("trap_mstatus", 12'h300, 32'h1880);
        peek("trap_drops_write", 12'h340, 32'hF00F);
        idle();
        bus.i_mret = 1;
        cyc();
        peek("mret_mstatus", 12'h300, 32'h1888);
        // interrupt gating, cause selection and vectored target
        wr(12'h304, 2'd0, 32'h880);
        bus.i_irq_ext = 1; bus.i_irq_timer = 1;
        idle();
        half();
        chk("irq_both_pending", 32'(bus.o_irq_pending), 32'h1);
        chk("irq_both_cause", bus.o_irq_cause, 32'h8000_000B);
        fin();
        bus.i_irq_ext = 0;
        half();
        chk("irq_timer_cause", bus.o_irq_cause, 32'h8000_0007);
        fin();
        wr(12'h305, 2'd0, 32'h1001);
        bus.i_trap_cause = 32'h8000_0007;
        idle();
        half();
        chk("vectored_target", bus.o_trap_target, 32'h101C);
        fin();
        // reset outranks trap, mret and writes in the same cycle
        idle();
        reset = 1; bus.i_trap = 1; bus.i_mret = 1; bus.i_we = 1; bus.i_a = 12'h340; bus.i_di = 32'h77;
        cyc();
        peek("rst_mid_mscratch", 12'h340, 32'h0);
        peek("rst_mid_mepc", 12'h341, 32'h0);
        peek("rst_mid_mstatus", 12'h300, 32'h1800);
`ifdef CSR_COUNTERS_EN
        wr(12'hB00, 2'd0, 32'hFFFF_FFFF);
        wr(12'hB80, 2'd0, 32'h0);
        idle();
        cyc();
        bus.i_a = 12'hB80;
        half();
        chk("mcycle_carry_hi", bus.o_do, 32'h1);
        bus.i_a = 12'hB00;
        #1;
        chk("mcycle_carry_lo", bus.o_do, 32'h0);
        fin();
        idle();
        reset = 1;
        cyc();
        idle();
        bus.i_retire = 1;
        repeat (3) cyc();
        peek("minstret_three", 12'hB02, 32'h3);
`else
        idle();
        bus.i_a = 12'hB00;
        half();
        chk("no_counters_illegal", 32'(bus.o_illegal), 32'h1);
        chk("no_counters_do", bus.o_do, 32'h0);
        fin();
`endif
        for (int i = 0; i < 400; i++) begin
            idle();
            bus.i_we = 1'($urandom % 2);
            bus.i_op = 2'($urandom % 4);
            bus.i_a = addrs[$urandom % 20];
            bus.i_di = ($urandom % 4 == 0) ? ($urandom % 16) : $urandom;
            bus.i_trap = ($urandom % 12 == 0);
            bus.i_mret = ($urandom % 8 == 0);
            bus.i_trap_pc = $urandom;
            bus.i_trap_val = $urandom;
            bus.i_trap_cause = ($urandom % 2 == 0) ? $urandom : ($urandom % 16);
            bus.i_retire = 1'($urandom % 2);
            bus.i_irq_ext = 1'($urandom % 2);
            bus.i_irq_timer = 1'($urandom % 2);
            reset = ($urandom % 80 == 0);
            cyc();
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
